// File: rtl/pipeline_hazard_ctrl_if.sv
// Purpose: bundles the decode-side hazard inputs and pipeline-register controls.
// Latency: none, wires only.
// Backpressure: none; the controls themselves are the pipeline's stall mechanism.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic             ex_MemRead;
    logic [4:0]       ex_rt;
    logic             branch_taken;
    logic             mem_req;
    logic             mem_ack;
    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_write;
    logic             id_ex_bubble;
    logic             ex_mem_write;
    logic             ex_mem_flush;
    logic             mem_wb_write;
    logic [CNT_W-1:0] stall_cycles;
    logic             bus_timeout;

    // Pipeline side: supplies decode/EX/MEM status, consumes the controls.
    modport master (
        output id_rs, id_rt, id_uses_rt, ex_MemRead, ex_rt,
               branch_taken, mem_req, mem_ack,
        input  pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
               ex_mem_write, ex_mem_flush, mem_wb_write, stall_cycles, bus_timeout
    );

    // Controller side.
    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_MemRead, ex_rt,
               branch_taken, mem_req, mem_ack,
        output pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
               ex_mem_write, ex_mem_flush, mem_wb_write, stall_cycles, bus_timeout
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Purpose: load-use bubble, branch flush and memory-wait freeze control for a 5-stage pipeline.
// Latency: controls are combinational from current state and inputs; state updates on the next edge.
// Backpressure: a pending data-memory access freezes every stage until mem_ack or TIMEOUT cycles.
module pipeline_hazard_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    pipeline_hazard_ctrl_if.slave bus
);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t           state;
    logic             pending_flush;
    logic [7:0]       wait_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic             timeout_flag;

    logic hazard;
    logic freeze_start;
    logic wait_release;

    // Load in EX whose destination is read by the instruction in ID.
    assign hazard = bus.ex_MemRead && (bus.ex_rt != 5'd0) &&
                    ((bus.ex_rt == bus.id_rs) ||
                     (bus.id_uses_rt && (bus.ex_rt == bus.id_rt)));

    assign freeze_start = bus.mem_req && !bus.mem_ack;

    // Leaving MEM_WAIT: the access completed, or the wait budget is exhausted
    // (the entry cycle counted as the first frozen cycle).
    assign wait_release = bus.mem_ack || (wait_cnt == 8'(TIMEOUT));

    // Pipeline-register and PC controls, forced idle while reset is held.
    always_comb begin
        bus.pc_write     = 1'b0;
        bus.if_id_write  = 1'b0;
        bus.if_id_flush  = 1'b0;
        bus.id_ex_write  = 1'b0;
        bus.id_ex_bubble = 1'b0;
        bus.ex_mem_write = 1'b0;
        bus.ex_mem_flush = 1'b0;
        bus.mem_wb_write = 1'b0;
        if (reset_n) begin
            case (state)
                RUN: begin
                    if (!freeze_start) begin
                        bus.pc_write     = 1'b1;
                        bus.if_id_write  = 1'b1;
                        bus.id_ex_write  = 1'b1;
                        bus.ex_mem_write = 1'b1;
                        bus.mem_wb_write = 1'b1;
                        if (bus.branch_taken) begin
                            bus.if_id_flush  = 1'b1;
                            bus.id_ex_bubble = 1'b1;
                            bus.ex_mem_flush = 1'b1;
                        end else if (hazard) begin
                            bus.pc_write     = 1'b0;
                            bus.if_id_write  = 1'b0;
                            bus.id_ex_bubble = 1'b1;
                        end
                    end
                end
                MEM_WAIT: begin
                    if (wait_release) begin
                        bus.pc_write     = 1'b1;
                        bus.if_id_write  = 1'b1;
                        bus.id_ex_write  = 1'b1;
                        bus.ex_mem_write = 1'b1;
                        bus.mem_wb_write = 1'b1;
                        // A branch seen while frozen, or resolving now, redirects on release.
                        if (pending_flush || bus.branch_taken) begin
                            bus.if_id_flush  = 1'b1;
                            bus.id_ex_bubble = 1'b1;
                            bus.ex_mem_flush = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Wait FSM, pending branch flush, stall counter and sticky timeout flag.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state         <= RUN;
            pending_flush <= 1'b0;
            wait_cnt      <= 8'd0;
            stall_cnt     <= '0;
            timeout_flag  <= 1'b0;
        end else begin
            if (!bus.pc_write && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            case (state)
                RUN: begin
                    if (freeze_start) begin
                        state         <= MEM_WAIT;
                        wait_cnt      <= 8'd1;
                        pending_flush <= bus.branch_taken;
                    end
                end
                MEM_WAIT: begin
                    if (wait_release) begin
                        state         <= RUN;
                        wait_cnt      <= 8'd0;
                        pending_flush <= 1'b0;
                        if (!bus.mem_ack) begin
                            timeout_flag <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                        if (bus.branch_taken) begin
                            pending_flush <= 1'b1;
                        end
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    assign bus.stall_cycles = stall_cnt;
    assign bus.bus_timeout  = timeout_flag;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Purpose: directed checks of bubble, flush, memory-wait freeze, timeout and reset behaviour.
// Latency: controls are sampled 1-2 time units after inputs change, well away from the clock edge.
// Backpressure: the bench plays the memory, holding mem_ack low to exercise the freeze.
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W = 16;

    // Control vector order: pc_write, if_id_write, if_id_flush, id_ex_write,
    // id_ex_bubble, ex_mem_write, ex_mem_flush, mem_wb_write.
    localparam logic [7:0] C_OFF   = 8'b0000_0000;
    localparam logic [7:0] C_RUN   = 8'b1101_0101;
    localparam logic [7:0] C_HAZ   = 8'b0001_1101;
    localparam logic [7:0] C_FLUSH = 8'b1111_1111;

    logic clock;
    logic reset_n;
    int   errors;
    int   checks;

    pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipeline_hazard_ctrl #(
        .TIMEOUT (8),
        .CNT_W   (CNT_W)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    logic [7:0] ctrl;
    assign ctrl = {bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_write,
                   bus.id_ex_bubble, bus.ex_mem_write, bus.ex_mem_flush, bus.mem_wb_write};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctrl(input string tag, input logic [7:0] exp);
        #1;
        chk(tag, {24'd0, ctrl}, {24'd0, exp});
    endtask

    task automatic idle_inputs();
        bus.id_rs        = 5'd0;
        bus.id_rt        = 5'd0;
        bus.id_uses_rt   = 1'b0;
        bus.ex_MemRead   = 1'b0;
        bus.ex_rt        = 5'd0;
        bus.branch_taken = 1'b0;
        bus.mem_req      = 1'b0;
        bus.mem_ack      = 1'b0;
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        reset_n = 1'b0;
        idle_inputs();

        // Reset
        tick();
        tick();
        chk_ctrl("reset_ctrl", C_OFF);
        chk("reset_stall", {16'd0, bus.stall_cycles}, 32'd0);
        chk("reset_timeout", {31'd0, bus.bus_timeout}, 32'd0);
        reset_n = 1'b1;
        chk_ctrl("idle_run", C_RUN);
        tick();

        // Load-use on rs
        bus.ex_MemRead = 1'b1; bus.ex_rt = 5'd5; bus.id_rs = 5'd5;
        chk_ctrl("loaduse_rs", C_HAZ);
        chk("loaduse_stall_before", {16'd0, bus.stall_cycles}, 32'd0);
        tick();
        chk("loaduse_stall_after", {16'd0, bus.stall_cycles}, 32'd1);
        idle_inputs();
        chk_ctrl("loaduse_one_cycle", C_RUN);
        tick();

        // Load to $zero never stalls
        bus.ex_MemRead = 1'b1; bus.ex_rt = 5'd0; bus.id_rs = 5'd0;
        chk_ctrl("rt_zero_no_stall", C_RUN);
        tick();
        chk("rt_zero_stall_cnt", {16'd0, bus.stall_cycles}, 32'd1);

        // Load-use on rt only when the ID instruction reads rt
        bus.ex_rt = 5'd7; bus.id_rs = 5'd3; bus.id_rt = 5'd7; bus.id_uses_rt = 1'b1;
        chk_ctrl("loaduse_rt", C_HAZ);
        tick();
        bus.id_uses_rt = 1'b0;
        chk_ctrl("rt_not_used", C_RUN);
        tick();
        chk("rt_stall_cnt", {16'd0, bus.stall_cycles}, 32'd2);

        // Branch beats hazard
        bus.ex_MemRead = 1'b1; bus.ex_rt = 5'd5; bus.id_rs = 5'd5; bus.branch_taken = 1'b1;
        chk_ctrl("branch_over_hazard", C_FLUSH);
        tick();
        chk("branch_stall_cnt", {16'd0, bus.stall_cycles}, 32'd2);
        idle_inputs();

        // Memory wait: four frozen cycles, hazard ignored while frozen
        bus.mem_req = 1'b1;
        chk_ctrl("memwait_c1", C_OFF);
        tick();
        chk_ctrl("memwait_c2", C_OFF);
        tick();
        bus.ex_MemRead = 1'b1; bus.ex_rt = 5'd4; bus.id_rs = 5'd4;
        chk_ctrl("memwait_c3_hazard", C_OFF);
        tick();
        bus.ex_MemRead = 1'b0;
        chk_ctrl("memwait_c4", C_OFF);
        tick();
        bus.mem_ack = 1'b1;
        chk_ctrl("memwait_ack", C_RUN);
        tick();
        chk("memwait_stall_cnt", {16'd0, bus.stall_cycles}, 32'd6);
        idle_inputs();
        chk_ctrl("memwait_back_run", C_RUN);
        tick();

        // Branch during the wait is deferred to the ack cycle
        bus.mem_req = 1'b1;
        chk_ctrl("brwait_c1", C_OFF);
        tick();
        bus.branch_taken = 1'b1;
        chk_ctrl("brwait_c2_branch", C_OFF);
        tick();
        bus.branch_taken = 1'b0;
        chk_ctrl("brwait_c3", C_OFF);
        tick();
        bus.mem_ack = 1'b1;
        chk_ctrl("brwait_ack_flush", C_FLUSH);
        tick();
        chk("brwait_stall_cnt", {16'd0, bus.stall_cycles}, 32'd9);
        idle_inputs();
        chk_ctrl("brwait_no_reflush", C_RUN);
        tick();

        // Request acknowledged in the same cycle never freezes
        bus.mem_req = 1'b1; bus.mem_ack = 1'b1;
        chk_ctrl("same_cycle_ack", C_RUN);
        tick();
        chk("same_cycle_stall_cnt", {16'd0, bus.stall_cycles}, 32'd9);
        idle_inputs();

        // Timeout: 8 frozen cycles, release, sticky flag
        bus.mem_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk_ctrl($sformatf("timeout_frozen_%0d", i + 1), C_OFF);
            tick();
        end
        chk_ctrl("timeout_release", C_RUN);
        chk("timeout_flag_before", {31'd0, bus.bus_timeout}, 32'd0);
        tick();
        chk("timeout_flag_set", {31'd0, bus.bus_timeout}, 32'd1);
        chk("timeout_stall_cnt", {16'd0, bus.stall_cycles}, 32'd17);
        idle_inputs();
        bus.ex_MemRead = 1'b1; bus.ex_rt = 5'd9; bus.id_rs = 5'd9;
        chk_ctrl("after_timeout_hazard", C_HAZ);
        tick();
        idle_inputs();
        chk("after_timeout_stall_cnt", {16'd0, bus.stall_cycles}, 32'd18);
        chk("timeout_flag_sticky", {31'd0, bus.bus_timeout}, 32'd1);
        tick();

        // Reset during the wait discards the pending flush
        bus.mem_req = 1'b1; bus.branch_taken = 1'b1;
        chk_ctrl("rstwait_c1", C_OFF);
        tick();
        bus.branch_taken = 1'b0;
        chk_ctrl("rstwait_c2", C_OFF);
        tick();
        reset_n = 1'b0;
        chk_ctrl("rstwait_in_reset", C_OFF);
        tick();
        reset_n = 1'b1;
        idle_inputs();
        chk_ctrl("rstwait_run_no_flush", C_RUN);
        chk("rstwait_stall_cnt", {16'd0, bus.stall_cycles}, 32'd0);
        chk("rstwait_timeout", {31'd0, bus.bus_timeout}, 32'd0);
        tick();
        bus.mem_ack = 1'b1;
        chk_ctrl("rstwait_late_ack", C_RUN);
        tick();
        idle_inputs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
